// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the USB receive packet sequencer:
//   - 4-bit PID codes for the tokens and data packets the sequencer handles
//   - sequencer state enumeration
//   - decoded SYNC byte value
//   - PID check helper (upper nibble must be the complement of the lower)
// -----------------------------------------------------------------------------
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  // SYNC field 00000001 on the wire, LSB first.
  localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PID       = 3'd1,
    ST_TOKEN     = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_DATA      = 3'd4,
    ST_HANDSHAKE = 3'd5,
    ST_DISCARD   = 3'd6
  } seq_state_e;

  // A PID byte is well formed when its check nibble is the complement of the PID.
  function automatic logic pid_check_ok(input logic [7:0] pid_byte);
    return (pid_byte[7:4] == ~pid_byte[3:0]);
  endfunction

endpackage

// File: rtl/usb_crc_strip.sv
// -----------------------------------------------------------------------------
// usb_crc_strip
// Two-byte delay line that holds back the trailing CRC16 of a data packet.
// A byte pushed while two bytes are already held pushes the oldest one out.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_push, i_byte   push a new byte into the line
//   i_flush          drop held bytes (end of packet); applied after a push
//                    in the same cycle
//   i_clear          empty the line at the start of a packet
//   o_byte_out       byte leaving the line (registered)
//   o_valid_out      one-cycle strobe qualifying o_byte_out
//   o_held           number of bytes currently held (0..2)
// -----------------------------------------------------------------------------
module usb_crc_strip
  import usb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_flush,
  input  logic       i_clear,
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte_out,
  output logic       o_valid_out,
  output logic [1:0] o_held
);

  logic [7:0] r_b0;     // oldest held byte
  logic [7:0] r_b1;     // newest held byte
  logic [1:0] r_held;
  logic [7:0] r_out;
  logic       r_valid;

  // Delay line shift register and output strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_b0    <= 8'h00;
      r_b1    <= 8'h00;
      r_held  <= 2'd0;
      r_out   <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_held  <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_push) begin
        case (r_held)
          2'd0: begin
            r_b0   <= i_byte;
            r_held <= 2'd1;
          end
          2'd1: begin
            r_b1   <= i_byte;
            r_held <= 2'd2;
          end
          default: begin
            r_out   <= r_b0;
            r_valid <= 1'b1;
            r_b0    <= r_b1;
            r_b1    <= i_byte;
          end
        endcase
      end
      // Flush wins over the push's count update: held CRC bytes are dropped.
      if (i_flush) begin
        r_held <= 2'd0;
      end
    end
  end

  assign o_byte_out  = r_out;
  assign o_valid_out = r_valid;
  assign o_held      = r_held;

endmodule

// File: rtl/usb_rx_pkt_sequencer.sv
// -----------------------------------------------------------------------------
// usb_rx_pkt_sequencer
// Packet-level sequencer behind the USB receive datapath. Parses PIDs and
// OUT/SETUP tokens against DEV_ADDR/DEV_ENDP, strips the CRC16 from DATA0/1
// payloads, forwards payload bytes downstream and requests ACK/NAK handshakes.
//
// Optional feature macro: USB_RX_TOGGLE_CHECK_EN
//   defined   : DATA0/DATA1 toggle tracking with duplicate suppression
//   undefined : every good accepted data packet is committed, data_toggle = 0
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_rx_receiving      receive controller is inside a packet
//   i_rx_byte_valid     strobe: i_rx_byte holds a new byte
//   i_rx_byte           received byte
//   i_rx_eop            strobe: end of packet
//   i_rx_crc_ok         CRC result, valid with i_rx_eop
//   i_rx_error          receive controller error
//   i_payload_ready     downstream has room for MAX_PAYLOAD bytes
//   o_payload_data/valid forwarded payload byte and strobe
//   o_pkt_commit        strobe: forwarded payload is good and new
//   o_pkt_abort         strobe: forwarded payload must be discarded
//   o_hs_valid, o_hs_ack handshake request (ack=1 ACK, ack=0 NAK)
//   o_data_toggle       expected DATA PID (0 = DATA0, 1 = DATA1)
//   o_busy              sequencer not idle
// -----------------------------------------------------------------------------
module usb_rx_pkt_sequencer
  import usb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR      = 7'h05,
  parameter logic [3:0] DEV_ENDP      = 4'h1,
  parameter int         MAX_PAYLOAD   = 64,
  parameter int         TOKEN_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_receiving,
  input  logic       i_rx_byte_valid,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_eop,
  input  logic       i_rx_crc_ok,
  input  logic       i_rx_error,
  input  logic       i_payload_ready,
  output logic [7:0] o_payload_data,
  output logic       o_payload_valid,
  output logic       o_pkt_commit,
  output logic       o_pkt_abort,
  output logic       o_hs_valid,
  output logic       o_hs_ack,
  output logic       o_data_toggle,
  output logic       o_busy
);

  localparam int TW  = $clog2(TOKEN_TIMEOUT + 1);
  localparam int PCW = $clog2(MAX_PAYLOAD + 1);

  seq_state_e     r_state, w_state_nxt;
  logic [7:0]     r_pid_byte, w_pid_byte_nxt;
  logic           r_pid_eop, w_pid_eop_nxt;       // PID byte arrived with EOP
  logic           r_armed, w_armed_nxt;
  logic           r_tok_setup, w_tok_setup_nxt;   // token being collected is SETUP
  logic           r_armed_setup, w_armed_setup_nxt;
  logic [1:0]     r_tok_cnt, w_tok_cnt_nxt;
  logic [7:0]     r_tok_b1, w_tok_b1_nxt;
  logic [2:0]     r_tok_b2, w_tok_b2_nxt;         // only the ENDP bits are kept
  logic [TW-1:0]  r_timer, w_timer_nxt;
  logic           r_ready, w_ready_nxt;           // payload_ready sampled at DATA entry
  logic           r_fwd, w_fwd_nxt;               // a payload byte has been forwarded
  logic [PCW-1:0] r_pay_cnt, w_pay_cnt_nxt;
  logic           r_commit, w_commit;
  logic           r_abort, w_abort;
  logic           r_hs_valid, w_hs_valid;
  logic           r_hs_ack, w_hs_ack;
  logic           r_busy;
  logic           w_tok_good;
  logic           w_push, w_flush, w_clear;
`ifdef USB_RX_TOGGLE_CHECK_EN
  logic           r_toggle, w_toggle_nxt;
  logic           r_pkt_toggle, w_pkt_toggle_nxt;
`endif

  logic [7:0]     w_strip_byte;
  logic           w_strip_valid;
  logic [1:0]     w_held;
  logic           w_overrun;
  logic [1:0]     w_held_after;
  logic           w_len_crc_ok;

  usb_crc_strip u_crc_strip (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_flush     (w_flush),
    .i_clear     (w_clear),
    .i_byte      (i_rx_byte),
    .o_byte_out  (w_strip_byte),
    .o_valid_out (w_strip_valid),
    .o_held      (w_held)
  );

  // A byte that would push out payload byte MAX_PAYLOAD+1 is an overrun.
  assign w_overrun    = i_rx_byte_valid && (w_held == 2'd2) &&
                        (r_pay_cnt == PCW'(MAX_PAYLOAD));
  // Bytes held after this cycle's push; fewer than 2 means no room for a CRC16.
  assign w_held_after = (i_rx_byte_valid && !w_overrun) ?
                        ((w_held == 2'd2) ? 2'd2 : (w_held + 2'd1)) : w_held;
  assign w_len_crc_ok = i_rx_crc_ok && (w_held_after == 2'd2);

  // Next-state, handshake outcome and delay-line control.
  always_comb begin
    w_state_nxt       = r_state;
    w_pid_byte_nxt    = r_pid_byte;
    w_pid_eop_nxt     = r_pid_eop;
    w_armed_nxt       = r_armed;
    w_tok_setup_nxt   = r_tok_setup;
    w_armed_setup_nxt = r_armed_setup;
    w_tok_cnt_nxt     = r_tok_cnt;
    w_tok_b1_nxt      = r_tok_b1;
    w_tok_b2_nxt      = r_tok_b2;
    w_timer_nxt       = r_timer;
    w_ready_nxt       = r_ready;
    w_fwd_nxt         = r_fwd;
    w_pay_cnt_nxt     = r_pay_cnt;
    w_commit          = 1'b0;
    w_abort           = 1'b0;
    w_hs_valid        = 1'b0;
    w_hs_ack          = 1'b0;
    w_push            = 1'b0;
    w_flush           = 1'b0;
    w_clear           = 1'b0;
    w_tok_good        = 1'b0;
`ifdef USB_RX_TOGGLE_CHECK_EN
    w_toggle_nxt      = r_toggle;
    w_pkt_toggle_nxt  = r_pkt_toggle;
`endif

    case (r_state)
      ST_IDLE: begin
        if (i_rx_byte_valid) begin
          w_pid_byte_nxt = i_rx_byte;
          w_pid_eop_nxt  = i_rx_eop;
          w_state_nxt    = ST_PID;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_PID: begin
        if (i_rx_error) begin
          w_state_nxt = i_rx_eop ? ST_IDLE : ST_DISCARD;
        end else if (r_pid_eop || i_rx_eop) begin
          // PID-only packet: nothing for this sequencer to do.
          w_state_nxt = ST_IDLE;
        end else if (!pid_check_ok(r_pid_byte)) begin
          w_state_nxt = ST_DISCARD;
        end else begin
          case (r_pid_byte[3:0])
            PID_OUT, PID_SETUP: begin
              w_state_nxt     = ST_TOKEN;
              w_tok_setup_nxt = (r_pid_byte[3:0] == PID_SETUP);
              w_tok_cnt_nxt   = 2'd0;
            end
            PID_DATA0, PID_DATA1: begin
              if (r_armed) begin
                w_state_nxt   = ST_DATA;
                w_ready_nxt   = i_payload_ready;
                w_fwd_nxt     = 1'b0;
                w_pay_cnt_nxt = {PCW{1'b0}};
                w_clear       = 1'b1;
`ifdef USB_RX_TOGGLE_CHECK_EN
                w_pkt_toggle_nxt = r_pid_byte[3];
`endif
              end else begin
                w_state_nxt = ST_DISCARD;
              end
            end
            default: w_state_nxt = ST_DISCARD;
          endcase
        end
      end

      ST_TOKEN: begin
        if (i_rx_error) begin
          w_state_nxt = i_rx_eop ? ST_IDLE : ST_DISCARD;
        end else begin
          if (i_rx_byte_valid) begin
            case (r_tok_cnt)
              2'd0:    w_tok_b1_nxt = i_rx_byte;
              2'd1:    w_tok_b2_nxt = i_rx_byte[2:0];
              default: w_tok_b1_nxt = r_tok_b1;
            endcase
            w_tok_cnt_nxt = (r_tok_cnt == 2'd3) ? 2'd3 : (r_tok_cnt + 2'd1);
          end else begin
            w_tok_cnt_nxt = r_tok_cnt;
          end
          // Byte (if any) is folded in before the EOP is judged.
          w_tok_good = i_rx_crc_ok && (w_tok_cnt_nxt == 2'd2) &&
                       (w_tok_b1_nxt[6:0] == DEV_ADDR) &&
                       ({w_tok_b2_nxt, w_tok_b1_nxt[7]} == DEV_ENDP);
          if (i_rx_eop) begin
            if (w_tok_good) begin
              w_state_nxt       = ST_WAIT_DATA;
              w_armed_nxt       = 1'b1;
              w_armed_setup_nxt = r_tok_setup;
              w_timer_nxt       = TW'(TOKEN_TIMEOUT - 1);
`ifdef USB_RX_TOGGLE_CHECK_EN
              w_toggle_nxt      = r_tok_setup ? 1'b0 : r_toggle;
`endif
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_TOKEN;
          end
        end
      end

      ST_WAIT_DATA: begin
        if (i_rx_error) begin
          w_state_nxt = i_rx_eop ? ST_IDLE : ST_DISCARD;
        end else if (i_rx_byte_valid) begin
          w_pid_byte_nxt = i_rx_byte;
          w_pid_eop_nxt  = i_rx_eop;
          w_state_nxt    = ST_PID;
        end else if (r_timer == {TW{1'b0}}) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end

      ST_DATA: begin
        if (i_rx_error) begin
          w_state_nxt = i_rx_eop ? ST_IDLE : ST_DISCARD;
          w_abort     = r_fwd;
        end else if (w_overrun) begin
          w_abort     = 1'b1;
          w_state_nxt = i_rx_eop ? ST_IDLE : ST_DISCARD;
        end else begin
          if (i_rx_byte_valid) begin
            w_push = 1'b1;
            if (w_held == 2'd2) begin
              w_pay_cnt_nxt = r_pay_cnt + PCW'(1);
              w_fwd_nxt     = r_fwd | r_ready;
            end else begin
              w_pay_cnt_nxt = r_pay_cnt;
            end
          end else begin
            w_push = 1'b0;
          end
          if (i_rx_eop) begin
            w_flush     = 1'b1;
            w_state_nxt = ST_HANDSHAKE;
            if (!w_len_crc_ok) begin
              w_abort = 1'b1;
            end else if (!r_ready) begin
              // SETUP must never be NAKed: accept it on the wire, drop the data.
              w_hs_valid = 1'b1;
              w_hs_ack   = r_armed_setup;
              w_abort    = r_armed_setup;
`ifdef USB_RX_TOGGLE_CHECK_EN
            end else if (r_pkt_toggle != r_toggle) begin
              // Retransmission of a packet already committed: ACK it again.
              w_hs_valid = 1'b1;
              w_hs_ack   = 1'b1;
              w_abort    = 1'b1;
`endif
            end else begin
              w_hs_valid = 1'b1;
              w_hs_ack   = 1'b1;
              w_commit   = 1'b1;
`ifdef USB_RX_TOGGLE_CHECK_EN
              w_toggle_nxt = ~r_toggle;
`endif
            end
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end

      ST_HANDSHAKE: begin
        if (i_rx_error && !i_rx_eop) begin
          w_state_nxt = ST_DISCARD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_DISCARD: begin
        // Also leave if the receive controller already dropped out of the packet.
        if (i_rx_eop || !i_rx_receiving) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DISCARD;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // A token only covers the data packet that immediately follows it.
    w_armed_nxt = ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DISCARD)) ?
                  1'b0 : w_armed_nxt;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_pid_byte    <= 8'h00;
      r_pid_eop     <= 1'b0;
      r_armed       <= 1'b0;
      r_tok_setup   <= 1'b0;
      r_armed_setup <= 1'b0;
      r_tok_cnt     <= 2'd0;
      r_tok_b1      <= 8'h00;
      r_tok_b2      <= 3'd0;
      r_timer       <= {TW{1'b0}};
      r_ready       <= 1'b0;
      r_fwd         <= 1'b0;
      r_pay_cnt     <= {PCW{1'b0}};
      r_commit      <= 1'b0;
      r_abort       <= 1'b0;
      r_hs_valid    <= 1'b0;
      r_hs_ack      <= 1'b0;
      r_busy        <= 1'b0;
`ifdef USB_RX_TOGGLE_CHECK_EN
      r_toggle      <= 1'b0;
      r_pkt_toggle  <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_pid_byte    <= w_pid_byte_nxt;
      r_pid_eop     <= w_pid_eop_nxt;
      r_armed       <= w_armed_nxt;
      r_tok_setup   <= w_tok_setup_nxt;
      r_armed_setup <= w_armed_setup_nxt;
      r_tok_cnt     <= w_tok_cnt_nxt;
      r_tok_b1      <= w_tok_b1_nxt;
      r_tok_b2      <= w_tok_b2_nxt;
      r_timer       <= w_timer_nxt;
      r_ready       <= w_ready_nxt;
      r_fwd         <= w_fwd_nxt;
      r_pay_cnt     <= w_pay_cnt_nxt;
      r_commit      <= w_commit;
      r_abort       <= w_abort;
      r_hs_valid    <= w_hs_valid;
      r_hs_ack      <= w_hs_ack;
      r_busy        <= (w_state_nxt != ST_IDLE);
`ifdef USB_RX_TOGGLE_CHECK_EN
      r_toggle      <= w_toggle_nxt;
      r_pkt_toggle  <= w_pkt_toggle_nxt;
`endif
    end
  end

  assign o_payload_data  = w_strip_byte;
  // r_ready is stable for the whole packet, so it can gate the strip output.
  assign o_payload_valid = w_strip_valid & r_ready;
  assign o_pkt_commit    = r_commit;
  assign o_pkt_abort     = r_abort;
  assign o_hs_valid      = r_hs_valid;
  assign o_hs_ack        = r_hs_ack;
  assign o_busy          = r_busy;
`ifdef USB_RX_TOGGLE_CHECK_EN
  assign o_data_toggle   = r_toggle;
`else
  assign o_data_toggle   = 1'b0;
`endif

endmodule
